// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and ALU control decode.
// Feeds the execute-stage ALU and carries memory/writeback control to the EX/MEM latch.
module id_ex_stage #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned REG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [WIDTH-1:0]    id_rs_data,
    input  logic [WIDTH-1:0]    id_rt_data,
    input  logic [WIDTH-1:0]    id_imm,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic [5:0]          id_funct,
    input  logic [1:0]          id_alu_op,
    input  logic                id_alu_src,
    input  logic                id_reg_dst,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                id_mem_to_reg,
    input  logic                exm_reg_write,
    input  logic [REG_BITS-1:0] exm_rd,
    input  logic [WIDTH-1:0]    exm_result,
    input  logic                wb_reg_write,
    input  logic [REG_BITS-1:0] wb_rd,
    input  logic [WIDTH-1:0]    wb_data,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [2:0]          alu_control,
    output logic [WIDTH-1:0]    store_data,
    output logic [REG_BITS-1:0] ex_write_reg,
    output logic                ex_valid,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_mem_to_reg,
    output logic                illegal_funct
);

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_FUNCT = 2'b10,
        OP_OR    = 2'b11
    } alu_op_t;

    logic                valid;
    logic [WIDTH-1:0]    rs_data;
    logic [WIDTH-1:0]    rt_data;
    logic [WIDTH-1:0]    imm;
    logic [REG_BITS-1:0] rs;
    logic [REG_BITS-1:0] rt;
    logic [REG_BITS-1:0] rd;
    logic [5:0]          funct;
    alu_op_t             alu_op;
    logic                alu_src;
    logic                reg_dst;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;

    logic [WIDTH-1:0]    fwd_rs;
    logic [WIDTH-1:0]    fwd_rt;
    logic                funct_known;

    // Flush clears only valid and control; data fields may stay stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= 1'b0;
            rs_data    <= '0;
            rt_data    <= '0;
            imm        <= '0;
            rs         <= '0;
            rt         <= '0;
            rd         <= '0;
            funct      <= '0;
            alu_op     <= OP_ADD;
            alu_src    <= 1'b0;
            reg_dst    <= 1'b0;
            reg_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_to_reg <= 1'b0;
        end else if (flush) begin
            valid      <= 1'b0;
            alu_op     <= OP_ADD;
            alu_src    <= 1'b0;
            reg_dst    <= 1'b0;
            reg_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_to_reg <= 1'b0;
        end else if (!stall) begin
            valid      <= id_valid;
            rs_data    <= id_rs_data;
            rt_data    <= id_rt_data;
            imm        <= id_imm;
            rs         <= id_rs;
            rt         <= id_rt;
            rd         <= id_rd;
            funct      <= id_funct;
            alu_op     <= alu_op_t'(id_alu_op);
            alu_src    <= id_alu_src;
            reg_dst    <= id_reg_dst;
            reg_write  <= id_reg_write;
            mem_read   <= id_mem_read;
            mem_write  <= id_mem_write;
            mem_to_reg <= id_mem_to_reg;
        end
    end

    // EX/MEM has priority over MEM/WB; register 0 is never forwarded.
    always_comb begin
        fwd_rs = rs_data;
        if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs)) begin
            fwd_rs = exm_result;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
            fwd_rs = wb_data;
        end
    end

    always_comb begin
        fwd_rt = rt_data;
        if (exm_reg_write && (exm_rd != '0) && (exm_rd == rt)) begin
            fwd_rt = exm_result;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rt)) begin
            fwd_rt = wb_data;
        end
    end

    always_comb begin
        alu_control = 3'b010;
        funct_known = 1'b1;
        unique case (alu_op)
            OP_ADD: alu_control = 3'b010;
            OP_SUB: alu_control = 3'b110;
            OP_OR:  alu_control = 3'b001;
            OP_FUNCT: begin
                case (funct)
                    6'b100000: alu_control = 3'b010;
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
                    6'b101010: alu_control = 3'b111;
                    6'b100111: alu_control = 3'b100;
                    6'b101100: alu_control = 3'b011;
                    default: begin
                        alu_control = 3'b010;
                        funct_known = 1'b0;
                    end
                endcase
            end
            default: alu_control = 3'b010;
        endcase
    end

    assign alu_a         = fwd_rs;
    assign alu_b         = alu_src ? imm : fwd_rt;
    assign store_data    = fwd_rt;
    assign ex_write_reg  = reg_dst ? rd : rt;
    assign ex_valid      = valid;
    assign ex_reg_write  = valid & reg_write;
    assign ex_mem_read   = valid & mem_read;
    assign ex_mem_write  = valid & mem_write;
    assign ex_mem_to_reg = valid & mem_to_reg;
    assign illegal_funct = valid & (alu_op == OP_FUNCT) & ~funct_known;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, decode, forwarding, stall/flush, illegal funct.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_funct;
    logic [1:0]  id_alu_op;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] alu_a, alu_b, store_data;
    logic [2:0]  alu_control;
    logic [4:0]  ex_write_reg;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, illegal_funct;

    int checks = 0;
    int failures = 0;

    id_ex_stage #(.WIDTH(32), .REG_BITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .store_data(store_data),
        .ex_write_reg(ex_write_reg), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .illegal_funct(illegal_funct)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_funct = 0; id_alu_op = 0;
        id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0;
        id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0;
        clear_id();
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        wb_reg_write = 0; wb_rd = 0; wb_data = 0;
        #12;
        check("rst_alu_a", alu_a, 32'h0);
        check("rst_alu_b", alu_b, 32'h0);
        check("rst_alu_control", {29'b0, alu_control}, 32'h2);
        check("rst_store_data", store_data, 32'h0);
        check("rst_write_reg", {27'b0, ex_write_reg}, 32'h0);
        check("rst_ctrl", {26'b0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, illegal_funct}, 32'h0);
        rst_n = 1;
        tick();

        // R-type max
        id_valid = 1; id_rs_data = 32'hA; id_rt_data = 32'h7; id_alu_op = 2'b10;
        id_funct = 6'b101100; id_rs = 1; id_rt = 2; id_rd = 5; id_reg_dst = 1; id_reg_write = 1;
        tick();
        check("max_alu_a", alu_a, 32'hA);
        check("max_alu_b", alu_b, 32'h7);
        check("max_alu_control", {29'b0, alu_control}, 32'h3);
        check("max_write_reg", {27'b0, ex_write_reg}, 32'h5);
        check("max_reg_write", {31'b0, ex_reg_write}, 32'h1);
        check("max_illegal", {31'b0, illegal_funct}, 32'h0);

        // Forwarding priority
        id_rs = 3; id_rt = 3; id_rs_data = 32'h33; id_rt_data = 32'h44; id_funct = 6'b100000;
        exm_reg_write = 1; exm_rd = 3; exm_result = 32'h11;
        wb_reg_write = 1; wb_rd = 3; wb_data = 32'h22;
        tick();
        check("fwd_exm_a", alu_a, 32'h11);
        check("fwd_exm_b", alu_b, 32'h11);
        check("fwd_exm_store", store_data, 32'h11);
        exm_reg_write = 0;
        #1;
        check("fwd_wb_a", alu_a, 32'h22);
        check("fwd_wb_b", alu_b, 32'h22);
        // register 0 never forwarded even when both sources name it
        id_rs = 0; exm_reg_write = 1; exm_rd = 0; wb_rd = 0;
        tick();
        check("fwd_r0_a", alu_a, 32'h33);
        check("fwd_r0_b", alu_b, 32'h44);
        exm_reg_write = 0; wb_reg_write = 0;

        // lw via immediate path
        clear_id();
        id_valid = 1; id_alu_op = 2'b00; id_alu_src = 1; id_imm = 32'hFFFFFFFC;
        id_rs = 4; id_rs_data = 32'h55; id_rt = 8; id_rt_data = 32'h66; id_rd = 9;
        id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
        tick();
        check("lw_alu_b", alu_b, 32'hFFFFFFFC);
        check("lw_alu_control", {29'b0, alu_control}, 32'h2);
        check("lw_write_reg", {27'b0, ex_write_reg}, 32'h8);
        check("lw_mem_read", {31'b0, ex_mem_read}, 32'h1);
        check("lw_store_data", store_data, 32'h66);

        // Stall holds the lw while decode inputs and forwarding sources change
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            id_alu_op = 2'b01; id_alu_src = 0; id_rt = 12; id_rs_data = 32'hDEAD0000 + i;
            id_mem_read = 0; id_mem_write = 1;
            wb_reg_write = 1; wb_rd = 4; wb_data = 32'h90 + i;
            tick();
            check("stall_write_reg", {27'b0, ex_write_reg}, 32'h8);
            check("stall_alu_b", alu_b, 32'hFFFFFFFC);
            check("stall_alu_control", {29'b0, alu_control}, 32'h2);
            check("stall_mem_read", {30'b0, ex_mem_read, ex_mem_write}, 32'h2);
            check("stall_fwd_a", alu_a, 32'h90 + i);
        end
        wb_reg_write = 0;

        // Stall and flush together: bubble
        flush = 1;
        tick();
        check("flush_ctrl", {27'b0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 32'h0);
        stall = 0; flush = 0;

        // Control gated by id_valid=0
        clear_id();
        id_reg_write = 1; id_mem_write = 1; id_mem_read = 1;
        tick();
        check("invalid_ctrl", {28'b0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}, 32'h0);

        // Other alu_op / funct codes
        clear_id(); id_valid = 1; id_alu_op = 2'b01;
        tick();
        check("sub_control", {29'b0, alu_control}, 32'h6);
        id_alu_op = 2'b11;
        tick();
        check("ori_control", {29'b0, alu_control}, 32'h1);
        id_alu_op = 2'b10; id_funct = 6'b100111;
        tick();
        check("nor_control", {29'b0, alu_control}, 32'h4);
        id_funct = 6'b101010;
        tick();
        check("slt_control", {29'b0, alu_control}, 32'h7);

        // Illegal funct, then the same instruction flushed
        id_funct = 6'b111111;
        tick();
        check("illegal_control", {29'b0, alu_control}, 32'h2);
        check("illegal_flag", {31'b0, illegal_funct}, 32'h1);
        flush = 1;
        tick();
        check("illegal_flushed", {31'b0, illegal_funct}, 32'h0);
        flush = 0;

        // Asynchronous reset mid-cycle
        clear_id(); id_valid = 1; id_reg_write = 1; id_reg_dst = 1; id_rd = 7;
        id_alu_op = 2'b01; id_rs_data = 32'h1234;
        tick();
        check("pre_rst_reg_write", {31'b0, ex_reg_write}, 32'h1);
        #2 rst_n = 0;
        #1;
        check("async_rst_ctrl", {30'b0, ex_valid, ex_reg_write}, 32'h0);
        check("async_rst_control", {29'b0, alu_control}, 32'h2);
        check("async_rst_write_reg", {27'b0, ex_write_reg}, 32'h0);
        check("async_rst_alu_a", alu_a, 32'h0);
        rst_n = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
